// File: rtl/wb_axil_master_pkg.sv
// ----------------------------------------------------------------------------
// wb_axil_master_pkg
// Shared definitions for the Wishbone-to-AXI-Lite master bridge:
//   - state_t            : bridge FSM state encoding
//   - C_ERR_RDATA        : read data returned to Wishbone after a timeout
//   - C_DEFAULT_TIMEOUT  : default handshake timeout in cycles
//   - C_DEFAULT_TO_WIDTH : default timeout counter width
// ----------------------------------------------------------------------------
package wb_axil_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD_A = 3'd2,
        ST_RD_D = 3'd3,
        ST_ACK  = 3'd4
    } state_t;

    localparam logic [31:0] C_ERR_RDATA        = 32'hFFFF_FFFF;
    localparam int          C_DEFAULT_TIMEOUT  = 255;
    localparam int          C_DEFAULT_TO_WIDTH = 8;

endpackage

// File: rtl/wb_axil_master_if.sv
// ----------------------------------------------------------------------------
// wb_axil_master_if
// Bundles the Wishbone slave side and the AXI-Lite master side of the bridge.
//   modport master : the bridge itself (Wishbone slave, AXI-Lite master)
//   modport slave  : the surroundings (Wishbone master, AXI-Lite target)
// Wishbone: wbs_adr, wbs_wdata, wbs_sel, wbs_cyc, wbs_stb, wbs_we,
//           wbs_ack, wbs_rdata
// AXI-Lite: AW (m_awvalid/m_awaddr/m_awready), W (m_wvalid/m_wdata/m_wstrb/
//           m_wready), AR (m_arvalid/m_araddr/m_arready),
//           R (m_rvalid/m_rdata/m_rready). No B channel on this target.
// ----------------------------------------------------------------------------
interface wb_axil_master_if #(
    parameter int pADDR_WIDTH = 32,
    parameter int pDATA_WIDTH = 32
);
    localparam int STRB_WIDTH = pDATA_WIDTH / 8;

    // Wishbone
    logic [pADDR_WIDTH-1:0] wbs_adr;
    logic [pDATA_WIDTH-1:0] wbs_wdata;
    logic [STRB_WIDTH-1:0]  wbs_sel;
    logic                   wbs_cyc;
    logic                   wbs_stb;
    logic                   wbs_we;
    logic                   wbs_ack;
    logic [pDATA_WIDTH-1:0] wbs_rdata;

    // AXI-Lite
    logic                   m_awvalid;
    logic [pADDR_WIDTH-1:0] m_awaddr;
    logic                   m_awready;
    logic                   m_wvalid;
    logic [pDATA_WIDTH-1:0] m_wdata;
    logic [STRB_WIDTH-1:0]  m_wstrb;
    logic                   m_wready;
    logic                   m_arvalid;
    logic [pADDR_WIDTH-1:0] m_araddr;
    logic                   m_arready;
    logic                   m_rvalid;
    logic [pDATA_WIDTH-1:0] m_rdata;
    logic                   m_rready;

    modport master (
        input  wbs_adr, wbs_wdata, wbs_sel, wbs_cyc, wbs_stb, wbs_we,
        output wbs_ack, wbs_rdata,
        output m_awvalid, m_awaddr,
        input  m_awready,
        output m_wvalid, m_wdata, m_wstrb,
        input  m_wready,
        output m_arvalid, m_araddr,
        input  m_arready,
        input  m_rvalid, m_rdata,
        output m_rready
    );

    modport slave (
        output wbs_adr, wbs_wdata, wbs_sel, wbs_cyc, wbs_stb, wbs_we,
        input  wbs_ack, wbs_rdata,
        input  m_awvalid, m_awaddr,
        output m_awready,
        input  m_wvalid, m_wdata, m_wstrb,
        output m_wready,
        input  m_arvalid, m_araddr,
        output m_arready,
        output m_rvalid, m_rdata,
        input  m_rready
    );

endinterface

// File: rtl/axil_to_counter.sv
// ----------------------------------------------------------------------------
// axil_to_counter
// Handshake timeout counter for AXI-Lite masters.
//   axi_clk, axi_reset_n : clock, asynchronous active-low reset
//   clr                  : synchronous clear to zero (has priority over en)
//   en                   : count one cycle of waiting
//   expired              : count has reached pTIMEOUT (never when pTIMEOUT=0)
// The count freezes once expired so that a state which keeps waiting after
// the expiry cycle still sees expired, rather than the counter wrapping.
// ----------------------------------------------------------------------------
module axil_to_counter
    import wb_axil_master_pkg::*;
#(
    parameter int pTIMEOUT  = C_DEFAULT_TIMEOUT,
    parameter int pTO_WIDTH = C_DEFAULT_TO_WIDTH
) (
    input  logic axi_clk,
    input  logic axi_reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [pTO_WIDTH-1:0] LIMIT   = pTO_WIDTH'(pTIMEOUT);
    localparam bit                   ENABLED = (pTIMEOUT != 0);

    logic [pTO_WIDTH-1:0] cnt_reg;

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en && !expired) begin
            cnt_reg <= cnt_reg + pTO_WIDTH'(1);
        end
    end

    assign expired = ENABLED && (cnt_reg == LIMIT);

endmodule

// File: rtl/wb_axil_master.sv
// ----------------------------------------------------------------------------
// wb_axil_master
// Registered Wishbone-classic slave to AXI-Lite master bridge on axi_clk.
//   axi_clk     : sole clock
//   axi_reset_n : asynchronous active-low reset
//   bus         : wb_axil_master_if.master (Wishbone slave + AXI-Lite master)
//   timeout_err : sticky flag, set on any handshake timeout, cleared by reset
// Each Wishbone cycle becomes one AXI-Lite transaction. Valids are held until
// the target accepts; AW and W complete independently. wbs_ack pulses for one
// cycle only after completion or after the handshake timeout expires, so the
// Wishbone bus can never hang on a silent target.
// ----------------------------------------------------------------------------
module wb_axil_master
    import wb_axil_master_pkg::*;
#(
    parameter int pADDR_WIDTH = 32,
    parameter int pDATA_WIDTH = 32,
    parameter int pTIMEOUT    = C_DEFAULT_TIMEOUT,
    parameter int pTO_WIDTH   = C_DEFAULT_TO_WIDTH
) (
    input  logic               axi_clk,
    input  logic               axi_reset_n,
    wb_axil_master_if.master   bus,
    output logic               timeout_err
);

    localparam int                     STRB_WIDTH = pDATA_WIDTH / 8;
    localparam logic [pDATA_WIDTH-1:0] ERR_RDATA  = pDATA_WIDTH'(C_ERR_RDATA);

    state_t                 state_reg;
    logic                   awvalid_reg;
    logic                   wvalid_reg;
    logic                   arvalid_reg;
    logic                   rready_reg;
    logic                   ack_reg;
    logic                   aw_done_reg;
    logic                   w_done_reg;
    logic                   timeout_err_reg;
    logic [pADDR_WIDTH-1:0] addr_reg;
    logic [pDATA_WIDTH-1:0] wdata_reg;
    logic [STRB_WIDTH-1:0]  strb_reg;
    logic [pDATA_WIDTH-1:0] rdata_reg;

    logic wb_req;
    logic aw_fire;
    logic w_fire;
    logic aw_done_next;
    logic w_done_next;
    logic to_clr;
    logic to_en;
    logic to_expired;

    assign wb_req  = bus.wbs_cyc & bus.wbs_stb;
    assign aw_fire = awvalid_reg & bus.m_awready;
    assign w_fire  = wvalid_reg & bus.m_wready;

    // A channel counts as done from the edge its handshake is sampled on;
    // both "done" terms include the current-cycle handshake so simultaneous
    // completion moves straight to ACK.
    assign aw_done_next = aw_done_reg | aw_fire;
    assign w_done_next  = w_done_reg | w_fire;

    // Holding the counter clear in IDLE means it starts at zero on entry
    // to WR or RD_A.
    assign to_clr = (state_reg == ST_IDLE);
    assign to_en  = (state_reg == ST_WR) || (state_reg == ST_RD_A) ||
                    (state_reg == ST_RD_D);

    axil_to_counter #(
        .pTIMEOUT  (pTIMEOUT),
        .pTO_WIDTH (pTO_WIDTH)
    ) u_to_counter (
        .axi_clk     (axi_clk),
        .axi_reset_n (axi_reset_n),
        .clr         (to_clr),
        .en          (to_en),
        .expired     (to_expired)
    );

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_reg       <= ST_IDLE;
            awvalid_reg     <= 1'b0;
            wvalid_reg      <= 1'b0;
            arvalid_reg     <= 1'b0;
            rready_reg      <= 1'b0;
            ack_reg         <= 1'b0;
            aw_done_reg     <= 1'b0;
            w_done_reg      <= 1'b0;
            timeout_err_reg <= 1'b0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            strb_reg        <= '0;
            rdata_reg       <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (wb_req) begin
                        addr_reg <= bus.wbs_adr;
                        if (bus.wbs_we) begin
                            wdata_reg   <= bus.wbs_wdata;
                            strb_reg    <= bus.wbs_sel;
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                            aw_done_reg <= 1'b0;
                            w_done_reg  <= 1'b0;
                            state_reg   <= ST_WR;
                        end else begin
                            arvalid_reg <= 1'b1;
                            rready_reg  <= 1'b1;
                            state_reg   <= ST_RD_A;
                        end
                    end
                end

                ST_WR: begin
                    aw_done_reg <= aw_done_next;
                    w_done_reg  <= w_done_next;
                    if (aw_fire) awvalid_reg <= 1'b0;
                    if (w_fire)  wvalid_reg  <= 1'b0;
                    // Normal completion wins over a timeout in the same cycle.
                    if (aw_done_next && w_done_next) begin
                        ack_reg   <= 1'b1;
                        state_reg <= ST_ACK;
                    end else if (to_expired) begin
                        awvalid_reg     <= 1'b0;
                        wvalid_reg      <= 1'b0;
                        timeout_err_reg <= 1'b1;
                        ack_reg         <= 1'b1;
                        state_reg       <= ST_ACK;
                    end
                end

                ST_RD_A: begin
                    if (bus.m_arready) begin
                        arvalid_reg <= 1'b0;
                        // Combinational targets answer in the AR cycle.
                        if (bus.m_rvalid) begin
                            rdata_reg  <= bus.m_rdata;
                            rready_reg <= 1'b0;
                            ack_reg    <= 1'b1;
                            state_reg  <= ST_ACK;
                        end else begin
                            state_reg <= ST_RD_D;
                        end
                    end else if (to_expired) begin
                        arvalid_reg     <= 1'b0;
                        rready_reg      <= 1'b0;
                        rdata_reg       <= ERR_RDATA;
                        timeout_err_reg <= 1'b1;
                        ack_reg         <= 1'b1;
                        state_reg       <= ST_ACK;
                    end
                end

                ST_RD_D: begin
                    if (bus.m_rvalid) begin
                        rdata_reg  <= bus.m_rdata;
                        rready_reg <= 1'b0;
                        ack_reg    <= 1'b1;
                        state_reg  <= ST_ACK;
                    end else if (to_expired) begin
                        rready_reg      <= 1'b0;
                        rdata_reg       <= ERR_RDATA;
                        timeout_err_reg <= 1'b1;
                        ack_reg         <= 1'b1;
                        state_reg       <= ST_ACK;
                    end
                end

                ST_ACK: begin
                    // One-cycle pulse; the master drops stb on this edge.
                    ack_reg   <= 1'b0;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    awvalid_reg <= 1'b0;
                    wvalid_reg  <= 1'b0;
                    arvalid_reg <= 1'b0;
                    rready_reg  <= 1'b0;
                    ack_reg     <= 1'b0;
                    state_reg   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.wbs_ack   = ack_reg;
    assign bus.wbs_rdata = rdata_reg;
    assign bus.m_awvalid = awvalid_reg;
    assign bus.m_awaddr  = addr_reg;
    assign bus.m_wvalid  = wvalid_reg;
    assign bus.m_wdata   = wdata_reg;
    assign bus.m_wstrb   = strb_reg;
    assign bus.m_arvalid = arvalid_reg;
    assign bus.m_araddr  = addr_reg;
    assign bus.m_rready  = rready_reg;
    assign timeout_err   = timeout_err_reg;

endmodule

// File: tb/tb_wb_axil_master.sv
// ----------------------------------------------------------------------------
// tb_wb_axil_master
// Self-checking bench for wb_axil_master. Acts as Wishbone master and as a
// programmable AXI-Lite target (per-transaction ready/valid delays). Each
// request pushes its expected outcome to a scoreboard queue; the entry is
// popped and compared when wbs_ack arrives.
// ----------------------------------------------------------------------------
module tb_wb_axil_master;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic timeout_err;

    always #5 clk = ~clk;

    wb_axil_master_if #(.pADDR_WIDTH(32), .pDATA_WIDTH(32)) bus ();

    wb_axil_master #(
        .pADDR_WIDTH (32),
        .pDATA_WIDTH (32),
        .pTIMEOUT    (TO),
        .pTO_WIDTH   (8)
    ) dut (
        .axi_clk     (clk),
        .axi_reset_n (rst_n),
        .bus         (bus),
        .timeout_err (timeout_err)
    );

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic [31:0] rdata;
        int          ack_idx;
        int          a_cycles;
        int          d_cycles;
        bit          tmo;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata = 32'h0;
    bit          err_model = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.wbs_adr   = '0;
        bus.wbs_wdata = '0;
        bus.wbs_sel   = '0;
        bus.wbs_cyc   = 1'b0;
        bus.wbs_stb   = 1'b0;
        bus.wbs_we    = 1'b0;
        bus.m_awready = 1'b0;
        bus.m_wready  = 1'b0;
        bus.m_arready = 1'b0;
        bus.m_rvalid  = 1'b0;
        bus.m_rdata   = '0;
    endtask

    // aw_dly / w_dly: number of valid cycles the target waits before ready.
    task automatic wb_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] sel, input int aw_dly, input int w_dly);
        exp_t        e;
        exp_t        got;
        int          idx;
        int          av_n;
        int          wv_n;
        bit          acked;
        logic [31:0] cap_awaddr;
        logic [31:0] cap_wdata;
        logic [3:0]  cap_wstrb;

        e.we       = 1'b1;
        e.addr     = addr;
        e.data     = data;
        e.sel      = sel;
        e.rdata    = last_rdata;
        e.ack_idx  = ((aw_dly > w_dly) ? aw_dly : w_dly) + 1;
        e.a_cycles = aw_dly + 1;
        e.d_cycles = w_dly + 1;
        e.tmo      = 1'b0;
        exp_q.push_back(e);

        bus.wbs_adr   = addr;
        bus.wbs_wdata = data;
        bus.wbs_sel   = sel;
        bus.wbs_we    = 1'b1;
        bus.wbs_cyc   = 1'b1;
        bus.wbs_stb   = 1'b1;

        idx = -1; av_n = 0; wv_n = 0; acked = 1'b0;
        cap_awaddr = '0; cap_wdata = '0; cap_wstrb = '0;
        for (int c = 0; c < 40 && !acked; c++) begin
            @(posedge clk); #1;
            idx++;
            if (bus.wbs_ack) begin
                acked = 1'b1;
            end else begin
                if (idx == 0)
                    check("wr_valid_latency", 32'({bus.m_awvalid, bus.m_wvalid}), 32'h3);
                bus.m_awready = 1'b0;
                bus.m_wready  = 1'b0;
                if (bus.m_awvalid) begin
                    av_n++;
                    if (aw_dly >= 0 && av_n - 1 >= aw_dly) begin
                        bus.m_awready = 1'b1;
                        cap_awaddr    = bus.m_awaddr;
                    end
                end
                if (bus.m_wvalid) begin
                    wv_n++;
                    if (w_dly >= 0 && wv_n - 1 >= w_dly) begin
                        bus.m_wready = 1'b1;
                        cap_wdata    = bus.m_wdata;
                        cap_wstrb    = bus.m_wstrb;
                    end
                end
            end
        end
        bus.m_awready = 1'b0;
        bus.m_wready  = 1'b0;

        got = exp_q.pop_front();
        if (!acked) begin
            check("wr_ack_seen", 32'(acked), 32'h1);
        end else begin
            check("wr_ack_latency", 32'(idx), 32'(got.ack_idx));
            check("wr_awvalid_cycles", 32'(av_n), 32'(got.a_cycles));
            check("wr_wvalid_cycles", 32'(wv_n), 32'(got.d_cycles));
            check("wr_awaddr", cap_awaddr, got.addr);
            check("wr_wdata", cap_wdata, got.data);
            check("wr_wstrb", 32'(cap_wstrb), 32'(got.sel));
            check("wr_rdata_held", bus.wbs_rdata, got.rdata);
            check("wr_timeout_err", 32'(timeout_err), 32'(err_model));
        end
        bus.wbs_cyc = 1'b0;
        bus.wbs_stb = 1'b0;
        bus.wbs_we  = 1'b0;
        @(posedge clk); #1;
        check("wr_ack_single", 32'(bus.wbs_ack), 32'h0);
        $display("write addr=0x%08h data=0x%08h sel=0x%h ack_idx=%0d", addr, data, sel, idx);
    endtask

    // ar_dly < 0 models a target that never answers.
    // r_dly: cycles from the AR handshake cycle to rvalid (0 = same cycle).
    task automatic wb_read(input logic [31:0] addr, input logic [31:0] resp,
                           input int ar_dly, input int r_dly);
        exp_t        e;
        exp_t        got;
        int          idx;
        int          ar_n;
        int          rr_n;
        int          hs_idx;
        bit          acked;
        logic [31:0] cap_araddr;

        e.we       = 1'b0;
        e.addr     = addr;
        e.data     = '0;
        e.sel      = '0;
        e.tmo      = (ar_dly < 0);
        e.rdata    = e.tmo ? 32'hFFFF_FFFF : resp;
        e.ack_idx  = e.tmo ? TO + 1 : ar_dly + r_dly + 1;
        e.a_cycles = e.tmo ? TO + 1 : ar_dly + 1;
        e.d_cycles = e.ack_idx;
        exp_q.push_back(e);

        bus.wbs_adr = addr;
        bus.wbs_we  = 1'b0;
        bus.wbs_cyc = 1'b1;
        bus.wbs_stb = 1'b1;

        idx = -1; ar_n = 0; rr_n = 0; hs_idx = -1; acked = 1'b0;
        cap_araddr = '0;
        for (int c = 0; c < 40 && !acked; c++) begin
            @(posedge clk); #1;
            idx++;
            if (bus.wbs_ack) begin
                acked = 1'b1;
            end else begin
                if (idx == 0) begin
                    check("rd_valid_latency", 32'({bus.m_arvalid, bus.m_rready}), 32'h3);
                    cap_araddr = bus.m_araddr;
                end
                bus.m_arready = 1'b0;
                bus.m_rvalid  = 1'b0;
                bus.m_rdata   = '0;
                if (bus.m_arvalid) begin
                    ar_n++;
                    if (ar_dly >= 0 && ar_n - 1 >= ar_dly) begin
                        bus.m_arready = 1'b1;
                        hs_idx        = idx;
                    end
                end
                if (bus.m_rready) begin
                    rr_n++;
                    if (hs_idx >= 0 && idx >= hs_idx + r_dly) begin
                        bus.m_rvalid = 1'b1;
                        bus.m_rdata  = resp;
                    end
                end
            end
        end
        bus.m_arready = 1'b0;
        bus.m_rvalid  = 1'b0;
        bus.m_rdata   = '0;

        got = exp_q.pop_front();
        if (!acked) begin
            check("rd_ack_seen", 32'(acked), 32'h1);
        end else begin
            if (got.tmo) err_model = 1'b1;
            check("rd_ack_latency", 32'(idx), 32'(got.ack_idx));
            check("rd_arvalid_cycles", 32'(ar_n), 32'(got.a_cycles));
            check("rd_rready_cycles", 32'(rr_n), 32'(got.d_cycles));
            check("rd_araddr", cap_araddr, got.addr);
            check("rd_rdata", bus.wbs_rdata, got.rdata);
            check("rd_timeout_err", 32'(timeout_err), 32'(err_model));
            last_rdata = got.rdata;
        end
        bus.wbs_cyc = 1'b0;
        bus.wbs_stb = 1'b0;
        @(posedge clk); #1;
        check("rd_ack_single", 32'(bus.wbs_ack), 32'h0);
        check("rd_rdata_hold", bus.wbs_rdata, last_rdata);
        $display("read  addr=0x%08h rdata=0x%08h ack_idx=%0d timeout_err=%0b",
                 addr, bus.wbs_rdata, idx, timeout_err);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_awvalid", 32'(bus.m_awvalid), 32'h0);
        check("rst_wvalid", 32'(bus.m_wvalid), 32'h0);
        check("rst_arvalid", 32'(bus.m_arvalid), 32'h0);
        check("rst_rready", 32'(bus.m_rready), 32'h0);
        check("rst_ack", 32'(bus.wbs_ack), 32'h0);
        check("rst_rdata", bus.wbs_rdata, 32'h0);
        check("rst_timeout_err", 32'(timeout_err), 32'h0);
        check("rst_awaddr", bus.m_awaddr, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Writes: immediate target, AW before W, W before AW.
        wb_write(32'h3000_5000, 32'h0000_0013, 4'hF, 0, 0);
        wb_write(32'h3000_5004, 32'hA5A5_0001, 4'h3, 2, 5);
        wb_write(32'h3000_5008, 32'h1234_ABCD, 4'hC, 4, 1);

        // Reads: combinational target, delayed data.
        wb_read(32'h3000_5000, 32'h0000_0013, 0, 0);
        wb_read(32'h3000_500C, 32'hDEAD_BEEF, 1, 4);
        wb_write(32'h3000_6000, 32'h0BAD_F00D, 4'h1, 1, 1);

        // Silent target: timeout, then sticky error through good traffic.
        wb_read(32'h3000_7000, 32'h5555_5555, -1, 0);
        wb_write(32'h3000_5010, 32'h0000_00FF, 4'hF, 0, 3);
        wb_read(32'h3000_5014, 32'h1234_5678, 2, 0);

        // Reset in the middle of a write whose target never answers.
        bus.wbs_adr   = 32'h3000_8000;
        bus.wbs_wdata = 32'h7777_7777;
        bus.wbs_sel   = 4'hF;
        bus.wbs_we    = 1'b1;
        bus.wbs_cyc   = 1'b1;
        bus.wbs_stb   = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("midrst_wvalid_before", 32'(bus.m_wvalid), 32'h1);
        rst_n = 1'b0;
        bus.wbs_cyc = 1'b0;
        bus.wbs_stb = 1'b0;
        bus.wbs_we  = 1'b0;
        #1;
        check("midrst_awvalid", 32'(bus.m_awvalid), 32'h0);
        check("midrst_wvalid", 32'(bus.m_wvalid), 32'h0);
        check("midrst_arvalid", 32'(bus.m_arvalid), 32'h0);
        check("midrst_rready", 32'(bus.m_rready), 32'h0);
        check("midrst_timeout_err", 32'(timeout_err), 32'h0);
        check("midrst_rdata", bus.wbs_rdata, 32'h0);
        repeat (2) begin
            @(posedge clk); #1;
            check("midrst_no_ack", 32'(bus.wbs_ack), 32'h0);
        end
        rst_n      = 1'b1;
        err_model  = 1'b0;
        last_rdata = 32'h0;
        $display("reset asserted mid-write, outputs returned to reset values");
        @(posedge clk); #1;

        wb_write(32'h3000_5020, 32'hCAFE_F00D, 4'hF, 1, 0);
        wb_read(32'h3000_5020, 32'hCAFE_F00D, 0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
